// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch sequencer: bus widths, the halt
// opcode, the sequencer state encoding and a saturating counter helper.
package cpu_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic [DATA_W-1:0] HALT_OP  = 8'hFF;
    localparam logic [ADDR_W-1:0] RESET_PC = 10'd0;
    localparam logic [ADDR_W-1:0] PC_MAX   = 10'h3FF;
    localparam logic [CNT_W-1:0]  CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/program_sequencer.sv
// Fetches one bytecode instruction at a time from program memory and hands it
// to the execute unit over valid/ready, following branch redirects until halt.
module program_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    input  logic              instr_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retire_cnt
);

    seq_state_t        state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [DATA_W-1:0] instr_r, instr_s;
    logic              valid_r, valid_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              halted_r, halted_s;
    logic              fault_r, fault_s;
    logic              mem_re_r;
    logic              running_r;
    logic              accept_s;

    // Next-state and datapath decisions for the fetch/issue sequence.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        valid_s  = valid_r;
        cnt_s    = cnt_r;
        halted_s = halted_r;
        fault_s  = fault_r;
        accept_s = (state_r == ISSUE) && valid_r && instr_ready;

        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (enable) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // Dropping enable here discards the returning byte; pc is kept so it is refetched.
                if (!enable) begin
                    state_s = IDLE;
                end else if (mem_rdata == HALT_OP) begin
                    state_s  = HALT;
                    halted_s = 1'b1;
                end else begin
                    instr_s = mem_rdata;
                    valid_s = 1'b1;
                    state_s = ISSUE;
                end
            end
            ISSUE: begin
                if (accept_s) begin
                    cnt_s   = sat_inc(cnt_r);
                    valid_s = 1'b0;
                    if (branch_valid) begin
                        pc_s    = branch_target;
                        state_s = enable ? FETCH : IDLE;
                    end else if (pc_r == PC_MAX) begin
                        fault_s  = 1'b1;
                        halted_s = 1'b1;
                        state_s  = HALT;
                    end else begin
                        pc_s    = pc_r + 10'd1;
                        state_s = enable ? FETCH : IDLE;
                    end
                end else if (!enable) begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= 8'h00;
            valid_r   <= 1'b0;
            cnt_r     <= 16'h0000;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
            mem_re_r  <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            instr_r   <= instr_s;
            valid_r   <= valid_s;
            cnt_r     <= cnt_s;
            halted_r  <= halted_s;
            fault_r   <= fault_s;
            mem_re_r  <= (state_s == FETCH);
            running_r <= (state_s == FETCH) || (state_s == WAIT) || (state_s == ISSUE);
        end
    end

    assign mem_re      = mem_re_r;
    assign mem_addr    = pc_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign pc          = pc_r;
    assign running     = running_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign retire_cnt  = cnt_r;

endmodule
